// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
// Circular-buffer prefetch queue between fetch and the IF/ID register.
// Holds up to DEPTH {PC, instruction} pairs with a show-ahead head entry.
// A flush (taken branch) empties the queue at the next edge.
// Optional feature macro: PREFETCH_BYPASS_EN. When it is defined, an
// incoming pair is forwarded combinationally while the queue is empty.
//
// Handshake: a push happens when in_valid & in_ready at a rising edge, and
// a pop happens when out_valid & out_ready at a rising edge. A flush in the
// same cycle cancels both. in_ready depends only on occupancy.
module instr_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_instruction,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_instruction,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [WIDTH-1:0] instr_mem_q [DEPTH];

  logic full, empty, push, pop;
  logic bypass_show, bypass_take;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

`ifdef PREFETCH_BYPASS_EN
  // An empty queue shows the incoming pair directly; if the consumer takes
  // it in the same cycle, it is never written to storage.
  assign bypass_show = empty & in_valid & ~flush;
  assign bypass_take = bypass_show & out_ready;
`else
  assign bypass_show = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push = in_valid & in_ready & ~flush & ~bypass_take;
  assign pop  = ~empty & out_ready & ~flush;

  assign in_ready  = ~full;
  assign out_valid = ~empty | bypass_show;
  assign count     = count_q;

  // Head entry when data is held, bypassed input when empty, otherwise zero
  always_comb begin
    out_pc          = '0;
    out_instruction = '0;
    if (!empty) begin
      out_pc          = pc_mem_q[rptr_q];
      out_instruction = instr_mem_q[rptr_q];
    end else if (bypass_show) begin
      out_pc          = in_pc;
      out_instruction = in_instruction;
    end
  end

  // Next-state for pointers and occupancy; flush overrides push and pop
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents are not cleared by reset or flush
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wptr_q]    <= in_pc;
      instr_mem_q[wptr_q] <= in_instruction;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed self-checking bench for instr_prefetch_queue (DEPTH=4, WIDTH=32).
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instruction;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic        out_ready;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  instr_prefetch_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_pc           (in_pc),
    .in_instruction  (in_instruction),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .out_ready       (out_ready),
    .count           (count)
  );

  // driver: advance one edge, settle 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present a pair (instruction derived from the PC)
  task automatic drive_pair(input logic [31:0] pc);
    in_valid       = 1'b1;
    in_pc          = pc;
    in_instruction = 32'hA500_0000 ^ pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instruction = '0;
    step();
    step();
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    // release reset mid-cycle with a pair waiting: accepted at the first edge
    drive_pair(32'h40);
    rst = 1'b0;
    step();
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL first_push_after_rst: got %0d expected 1", count); end
    drive_pair(32'h44);
    step();
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL second_push: got %0d expected 2", count); end
    // asynchronous reset mid-cycle, no clock edge in between
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL async_rst_count: got %0d expected 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL async_rst_out_pc: got %h expected 0", out_pc); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_in_ready: got %b expected 1", in_ready); end
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_%0d: got count=%0d valid=%b expected count=0 valid=0", i, count, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_pair(32'(4 * (i + 1)));
      step();
      n_cmp++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count_%0d: got %0d expected %0d", i, count, i + 1); end
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (out_pc !== 32'd4) begin n_fail++; $display("FAIL full_head_pc: got %h expected 4", out_pc); end
    n_cmp++; if (out_instruction !== (32'hA500_0000 ^ 32'd4)) begin n_fail++; $display("FAIL full_head_instr: got %h expected %h", out_instruction, 32'hA500_0000 ^ 32'd4); end
    drive_pair(32'd20);
    step();
    n_cmp++; if (count !== 3'd4 || out_pc !== 32'd4) begin n_fail++; $display("FAIL refused_push: got count=%0d pc=%h expected count=4 pc=4", count, out_pc); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL drain_%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, out_valid, out_pc, 4 * (i + 1)); end
      step();
    end
    n_cmp++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || count !== 3'd0) begin n_fail++; $display("FAIL drained_empty: got valid=%b pc=%h count=%0d expected 0 0 0", out_valid, out_pc, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      drive_pair(32'(4 * k));
`ifdef PREFETCH_BYPASS_EN
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_bypass_%0d: got valid=%b pc=%h expected valid=1 pc=%h", k, out_valid, out_pc, 4 * k); end
      step();
      n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_count_%0d: got %0d expected 0", k, count); end
`else
      step();
      n_cmp++; if (count !== 3'd1 || out_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_%0d: got count=%0d pc=%h expected count=1 pc=%h", k, count, out_pc, 4 * k); end
`endif
    end
    in_valid = 1'b0;
`ifndef PREFETCH_BYPASS_EN
    step();
`endif
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end: got count=%0d valid=%b expected 0 0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_pair(32'h100 + 32'(4 * i));
      step();
    end
    n_cmp++; if (count !== 3'd3 || out_pc !== 32'h100) begin n_fail++; $display("FAIL b2b_fill: got count=%0d pc=%h expected count=3 pc=100", count, out_pc); end
    drive_pair(32'h10C);
    out_ready = 1'b1;
    step();
    n_cmp++; if (count !== 3'd3 || out_pc !== 32'h104) begin n_fail++; $display("FAIL b2b_pushpop: got count=%0d pc=%h expected count=3 pc=104", count, out_pc); end
    drive_pair(32'h110);
    out_ready = 1'b0;
    step();
    n_cmp++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got count=%0d in_ready=%b expected count=4 in_ready=0", count, in_ready); end
    drive_pair(32'h114);
    out_ready = 1'b1;
    step();
    n_cmp++; if (count !== 3'd3 || out_pc !== 32'h108) begin n_fail++; $display("FAIL b2b_full_pop: got count=%0d pc=%h expected count=3 pc=108", count, out_pc); end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    // queue holds 0x108, 0x10C, 0x110 on entry
    drive_pair(32'h200);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin n_fail++; $display("FAIL flush_empty: got count=%0d valid=%b pc=%h expected 0 0 0", count, out_valid, out_pc); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    step();
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_hold: got %0d expected 0", count); end
    drive_pair(32'h300);
    step();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd1 || out_pc !== 32'h300) begin n_fail++; $display("FAIL post_flush_push: got count=%0d pc=%h expected count=1 pc=300", count, out_pc); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_flush_pop: got count=%0d valid=%b expected 0 0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    drive_pair(32'h100);
    out_ready = 1'b1;
    #1;
`ifdef PREFETCH_BYPASS_EN
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_fail++; $display("FAIL bypass_show: got valid=%b pc=%h expected valid=1 pc=100", out_valid, out_pc); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL bypass_take_count: got %0d expected 0", count); end
`else
    n_cmp++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin n_fail++; $display("FAIL no_bypass: got valid=%b pc=%h expected valid=0 pc=0", out_valid, out_pc); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd1 || out_pc !== 32'h100) begin n_fail++; $display("FAIL no_bypass_push: got count=%0d pc=%h expected count=1 pc=100", count, out_pc); end
    step();
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL no_bypass_drain: got %0d expected 0", count); end
`endif
    drive_pair(32'h180);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd1 || out_pc !== 32'h180) begin n_fail++; $display("FAIL stall_push: got count=%0d pc=%h expected count=1 pc=180", count, out_pc); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL stall_drain: got %0d expected 0", count); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_back_to_back();
    test_flush();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch queue between the fetch stage and the IF/ID pipeline register. It buffers up to DEPTH fetched {PC, instruction} pairs so fetch can keep running while decode is frozen by hazards. A taken branch from EXE discards everything held in one cycle. Output is show-ahead: the head entry is always visible, and the consumer pops it by asserting out_ready.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- WIDTH, 32, width of PC and instruction fields
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  taken-branch flush; discards all entries
- in_valid  input  1  fetch presents a valid pair
- in_pc  input  WIDTH  PC of the fetched instruction (already PC+4 as produced by fetch)
- in_instruction  input  WIDTH  fetched instruction word
- in_ready  output  1  queue accepts a push this cycle
- out_valid  output  1  head entry valid
- out_pc  output  WIDTH  head PC
- out_instruction  output  WIDTH  head instruction
- out_ready  input  1  consumer pops the head this cycle (driven as ~freeze)
- count  output  $clog2(DEPTH)+1  number of held entries

## Operation
- Storage is a circular buffer with a write pointer, a read pointer and an occupancy counter.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Derived signals:
  - full = (count == DEPTH); empty = (count == 0).
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- in_ready = ~full. It is combinational from count only, and never depends on out_ready (no pass-through when full).
- out_valid = ~empty. out_pc and out_instruction are the head entry when valid and 0 when empty.
- Push only: write at wptr, wptr+1, count+1.
- Pop only: rptr+1, count−1.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any count except full, where push cannot occur.
- Flush takes priority over everything.
  - Next edge: wptr = rptr = count = 0.
  - A push or pop presented in the flush cycle is discarded.
  - Storage contents need not be cleared.
- Reset behaves the same as flush, but takes effect asynchronously.

## Timing
- Reset values: count=0, out_valid=0, out_pc=0, out_instruction=0, in_ready=1. Pointers are 0.
- Latency (macro off): a pair pushed at edge N is visible on the outputs after edge N and can be popped at edge N+1. Minimum latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- Full: in_ready=0. in_valid is ignored and the upstream must hold its pair.
- Empty: out_valid=0. out_ready is ignored.
- Reset asserted mid-operation: all outputs go to their reset values immediately, with no clock required.
- Reset deassertion: the first push is accepted at the first rising edge after deassertion.

## Configuration
- PREFETCH_BYPASS_EN
  - Defined: when empty, in_valid=1 and flush=0, the outputs show in_pc/in_instruction combinationally with out_valid=1.
    - If out_ready=1, the pair is consumed that cycle and not written; count stays 0.
    - If out_ready=0, the pair is written normally.
    - Zero-cycle latency on empty.
  - Undefined: no combinational in→out path; 1-cycle minimum latency as described in Timing.

## Test plan
- Reset then idle: rst=1 mid-cycle → count=0, out_valid=0, out_pc=0, in_ready=1 asynchronously. Hold out_ready=1 with no pushes → no change.
- Fill and drain, out_ready=0: push PCs 4, 8, 12, 16 → count=4, in_ready=0, out_pc=4. A fifth push of PC 20 is refused. Set out_ready=1 → pops 4, 8, 12, 16 in order, then out_valid=0.
- Sustained streaming: in_valid=1 and out_ready=1 for 10 cycles with PCs 4..40 → count stays 1 (macro off) or 0 (macro on). Outputs appear in order with no gaps. Pointers wrap twice.
- Simultaneous push/pop at count=3 → count stays 3 and the head advances. At count=4 with out_ready=1 → push refused, count becomes 3.
- Flush priority: count=3, with in_valid=1, out_ready=1 and flush=1 in the same cycle → next cycle count=0, out_valid=0, and neither the pushed PC nor the popped entry is observed.
- Bypass (macro on): empty, push PC 0x100 with out_ready=1 → out_pc=0x100 in the same cycle and count stays 0. With out_ready=0 → count=1. Macro off → out_valid=0 in that cycle.
